hypothesis_batch_ctrl: RTL and testbench
========================================

Name: hypothesis_batch_ctrl

Overview:
Sequencer that runs the phase1 hypothesis datapath (h = x·teta, N_ELEMS lanes of DATA_W) over a batch of training samples held in an external sample memory. On start it latches teta, fetches each sample (feature vector x plus label y), drives the combinational datapath, and captures h. It accumulates absolute error |h − y| and reports sum, max and sample count on done. It sits between the training top-level and the phase1 instance.

Parameters:
N_ELEMS, 8, feature vector length
DATA_W, 8, element / label / h width
ADDR_W, 8, sample memory address width
CNT_W, 8, width of num_samples and sample counter
ERR_W, 16, width of saturating error sum

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  start request; accepted only in IDLE
abort  in  1  cancel batch; effective in any non-IDLE state
num_samples  in  CNT_W  samples in batch; latched on start accept
base_addr  in  ADDR_W  address of first sample; latched on start accept
theta_in  in  N_ELEMS*DATA_W  teta vector; latched on start accept
mem_rd_en  out  1  sample memory read strobe
mem_addr  out  ADDR_W  sample address
mem_rd_data  in  N_ELEMS*DATA_W+DATA_W  [N*DW-1:0]=x, top DATA_W bits=y; valid 1 cycle after mem_rd_en
dp_x  out  N_ELEMS*DATA_W  to phase1 x
dp_teta  out  N_ELEMS*DATA_W  to phase1 teta
dp_h  in  DATA_W  from phase1 h (combinational)
busy  out  1  batch in progress
done  out  1  one-cycle pulse, results valid
err_sum  out  ERR_W  saturating sum of |h−y|
err_max  out  DATA_W  max |h−y| in batch
samples_done  out  CNT_W  samples processed

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all outputs and internal registers 0.
- FSM: IDLE, RD, WAIT, EVAL, ACC, DONE.
- IDLE: start=1 -> latch num_samples, base_addr, theta_in; clear err_sum, err_max, samples_done, idx. If num_samples=0 -> DONE, else -> RD.
- RD: mem_rd_en=1, mem_addr=base_addr+idx (mod 2^ADDR_W, wraps silently) -> WAIT.
- WAIT: capture mem_rd_data into x_reg/y_reg at end of cycle -> EVAL.
- EVAL: dp_x=x_reg, dp_teta=teta_reg; capture dp_h into h_reg -> ACC.
- ACC: d = |h_reg − y_reg| (9-bit signed subtract, magnitude fits DATA_W). err_sum += d, saturating at 2^ERR_W−1. err_max = max(err_max,d). samples_done++, idx++. If idx+1 == num_samples -> DONE, else -> RD.
- DONE: done=1 for exactly one cycle -> IDLE. Results hold until next start accept or reset.
- mem_rd_en=1 only in RD. dp_teta = teta_reg in all states. dp_x = x_reg in all states, 0 after reset.
- busy=1 in RD/WAIT/EVAL/ACC, 0 in IDLE/DONE.
- Timing: start accepted in cycle 0 -> first RD in cycle 1 -> 4 cycles per sample -> done in cycle 4·N+1. For N=0, done in cycle 1.
- start while not IDLE: ignored, including in DONE.
- abort=1 in any non-IDLE state: -> IDLE next edge. No done pulse. err_sum/err_max/samples_done hold partial values. abort has priority over all transitions. abort in IDLE with start=1: start ignored.
- Reset mid-batch: same as power-on reset. No done.
- Input changes to num_samples/base_addr/theta_in while busy have no effect.

Decomposition:
- Shared package hyp_pkg: state enum (IDLE..DONE, 3-bit encoding), DATA_W/N_ELEMS defaults, and SAMPLE_W = N_ELEMS*DATA_W+DATA_W.
- One sub-module: err_accum. It holds the absolute-difference, saturating-sum and max-tracking logic, with clear/enable inputs.
- The FSM, address generation and datapath muxing stay in the top.

Test Plan:
- The bench models phase1 as h = low DATA_W bits of Σ x_i·teta_i.
- Single sample: theta lanes {0,…,2,4}, mem[0] x={0,…,2,4}, y=15, num_samples=1, base_addr=0 -> h=20; done in cycle 5; err_sum=5, err_max=5, samples_done=1; mem_rd_en high only in cycle 1.
- Batch of 3: base_addr=0xFE, y chosen for errors 3, 10, 1 -> addresses 0xFE, 0xFF, 0x00 (wrap); done in cycle 13; err_sum=14, err_max=10, samples_done=3.
- Zero batch: num_samples=0 -> no mem_rd_en; done in cycle 1; all results 0.
- Saturation: ERR_W=8, 2 samples each with error 200 -> err_sum=255, err_max=200.
- Abort: N=4, abort asserted in cycle 7 (second sample) -> IDLE in cycle 8, no done; samples_done=1, busy=0. A start issued during busy earlier is ignored.
- Reset mid-batch: rst_n=0 in cycle 6 -> all outputs 0 next cycle. A new start then completes normally.

Source files
------------

// File: rtl/hypothesis_batch_ctrl_pkg.sv
// Shared types and defaults for the hypothesis batch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hyp_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_EVAL = 3'd3,
        S_ACC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int DEF_N_ELEMS  = 8;
    localparam int DEF_DATA_W   = 8;
    // One memory word: feature vector x in the low bits, label y on top.
    localparam int DEF_SAMPLE_W = DEF_N_ELEMS * DEF_DATA_W + DEF_DATA_W;

endpackage

// File: rtl/hypothesis_batch_ctrl_err_accum.sv
// Absolute error |h - y| accumulator: saturating sum and running maximum.
// Latency: results update one cycle after en.
// Backpressure: none; clear wins over en when both are high.
module err_accum #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] y,
    output logic [ERR_W-1:0]  err_sum,
    output logic [DATA_W-1:0] err_max
);

    logic [DATA_W-1:0] diff;
    logic [ERR_W:0]    sum_ext;

    // Magnitude of the difference always fits DATA_W; one extra sum bit flags overflow.
    always_comb begin
        diff    = (h >= y) ? (h - y) : (y - h);
        sum_ext = {1'b0, err_sum} + (ERR_W+1)'(diff);
    end

    // Result registers: cleared on a new batch, updated once per accumulated sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sum <= '0;
            err_max <= '0;
        end else if (clear) begin
            err_sum <= '0;
            err_max <= '0;
        end else if (en) begin
            err_sum <= sum_ext[ERR_W] ? {ERR_W{1'b1}} : sum_ext[ERR_W-1:0];
            if (diff > err_max) begin
                err_max <= diff;
            end
        end
    end

endmodule

// File: rtl/hypothesis_batch_ctrl.sv
// Batch sequencer: fetch sample, drive hypothesis datapath, accumulate |h - y|.
// Latency: 4 cycles per sample; done pulses 4*N+1 cycles after start accept.
// Backpressure: start ignored unless idle; abort returns to idle from any busy state.
module hypothesis_batch_ctrl
    import hyp_pkg::*;
#(
    parameter int N_ELEMS = DEF_N_ELEMS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8,
    parameter int ERR_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [CNT_W-1:0]                  num_samples,
    input  logic [ADDR_W-1:0]                 base_addr,
    input  logic [N_ELEMS*DATA_W-1:0]         theta_in,
    output logic                              mem_rd_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [N_ELEMS*DATA_W+DATA_W-1:0]  mem_rd_data,
    output logic [N_ELEMS*DATA_W-1:0]         dp_x,
    output logic [N_ELEMS*DATA_W-1:0]         dp_teta,
    input  logic [DATA_W-1:0]                 dp_h,
    output logic                              busy,
    output logic                              done,
    output logic [ERR_W-1:0]                  err_sum,
    output logic [DATA_W-1:0]                 err_max,
    output logic [CNT_W-1:0]                  samples_done
);

    localparam int XW       = N_ELEMS * DATA_W;
    localparam int SAMPLE_W = XW + DATA_W;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    num_reg;
    logic [CNT_W-1:0]    idx;
    logic [ADDR_W-1:0]   base_reg;
    logic [XW-1:0]       teta_reg;
    logic [XW-1:0]       x_reg;
    logic [DATA_W-1:0]   y_reg;
    logic [DATA_W-1:0]   h_reg;
    logic                acc_clear;
    logic                acc_en;
    logic                cap_sample;
    logic                cap_h;
    logic                last;

    assign last = (({1'b0, idx} + (CNT_W+1)'(1)) == {1'b0, num_reg});

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; abort overrides every transition out of a busy state.
    always_comb begin
        state_nxt  = state;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        cap_sample = 1'b0;
        cap_h      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    acc_clear = 1'b1;
                    state_nxt = (num_samples == '0) ? S_DONE : S_RD;
                end
            end
            S_RD:   state_nxt = S_WAIT;
            S_WAIT: begin
                cap_sample = 1'b1;
                state_nxt  = S_EVAL;
            end
            S_EVAL: begin
                cap_h     = 1'b1;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                acc_en    = 1'b1;
                state_nxt = last ? S_DONE : S_RD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt  = S_IDLE;
            acc_en     = 1'b0;
            cap_sample = 1'b0;
            cap_h      = 1'b0;
        end
    end

    // Batch configuration, sample/hypothesis capture and progress counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_reg      <= '0;
            base_reg     <= '0;
            teta_reg     <= '0;
            idx          <= '0;
            samples_done <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            h_reg        <= '0;
        end else begin
            if (acc_clear) begin
                num_reg      <= num_samples;
                base_reg     <= base_addr;
                teta_reg     <= theta_in;
                idx          <= '0;
                samples_done <= '0;
            end
            if (cap_sample) begin
                x_reg <= mem_rd_data[XW-1:0];
                y_reg <= mem_rd_data[SAMPLE_W-1 -: DATA_W];
            end
            if (cap_h) begin
                h_reg <= dp_h;
            end
            if (acc_en) begin
                idx          <= idx + CNT_W'(1);
                samples_done <= samples_done + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from state; address wraps modulo the memory size.
    always_comb begin
        mem_rd_en = (state == S_RD);
        mem_addr  = base_reg + ADDR_W'(idx);
        dp_x      = x_reg;
        dp_teta   = teta_reg;
        busy      = (state == S_RD) || (state == S_WAIT) ||
                    (state == S_EVAL) || (state == S_ACC);
        done      = (state == S_DONE);
    end

    err_accum #(
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_err_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clear),
        .en      (acc_en),
        .h       (h_reg),
        .y       (y_reg),
        .err_sum (err_sum),
        .err_max (err_max)
    );

endmodule

// File: tb/tb_hypothesis_batch_ctrl.sv
// Directed bench for the batch sequencer with a behavioural phase1 and sample memory.
// Latency: checks done at cycle 4*N+1 relative to start accept.
// Backpressure: exercises ignored start, abort and mid-batch reset.
module tb_hypothesis_batch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  num_samples;
    logic [7:0]  base_addr;
    logic [63:0] theta_in;

    logic        a_mem_rd_en,  b_mem_rd_en;
    logic [7:0]  a_mem_addr,   b_mem_addr;
    logic [71:0] a_rd_data,    b_rd_data;
    logic [63:0] a_dp_x,       b_dp_x;
    logic [63:0] a_dp_teta,    b_dp_teta;
    logic [7:0]  a_dp_h,       b_dp_h;
    logic        a_busy,       b_busy;
    logic        a_done,       b_done;
    logic [15:0] a_err_sum;
    logic [7:0]  b_err_sum;
    logic [7:0]  a_err_max,    b_err_max;
    logic [7:0]  a_samples,    b_samples;

    logic [71:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    int   rd_cnt;
    int   rd_cyc  [0:7];
    logic [7:0] rd_addr [0:7];
    logic busy_c1;

    always #5 clk = ~clk;

    hypothesis_batch_ctrl #(.ERR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_samples(num_samples), .base_addr(base_addr), .theta_in(theta_in),
        .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr), .mem_rd_data(a_rd_data),
        .dp_x(a_dp_x), .dp_teta(a_dp_teta), .dp_h(a_dp_h),
        .busy(a_busy), .done(a_done), .err_sum(a_err_sum), .err_max(a_err_max),
        .samples_done(a_samples)
    );

    hypothesis_batch_ctrl #(.ERR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_samples(num_samples), .base_addr(base_addr), .theta_in(theta_in),
        .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rd_data(b_rd_data),
        .dp_x(b_dp_x), .dp_teta(b_dp_teta), .dp_h(b_dp_h),
        .busy(b_busy), .done(b_done), .err_sum(b_err_sum), .err_max(b_err_max),
        .samples_done(b_samples)
    );

    function automatic logic [7:0] phase1(input logic [63:0] x, input logic [63:0] t);
        logic [7:0] acc;
        acc = 8'd0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + x[i*8 +: 8] * t[i*8 +: 8];
        end
        return acc;
    endfunction

    function automatic logic [71:0] mk(input logic [7:0] y, input logic [7:0] x1, input logic [7:0] x0);
        return {y, 48'h0, x1, x0};
    endfunction

    always_comb a_dp_h = phase1(a_dp_x, a_dp_teta);
    always_comb b_dp_h = phase1(b_dp_x, b_dp_teta);

    // Sample memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (a_mem_rd_en) a_rd_data <= mem[a_mem_addr];
        if (b_mem_rd_en) b_rd_data <= mem[b_mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a batch in cycle 0 and records reads and the done cycle (-1 if none).
    task automatic run_batch(input logic [7:0] n, input logic [7:0] base, output int done_cyc);
        done_cyc    = -1;
        rd_cnt      = 0;
        busy_c1     = 1'b0;
        num_samples = n;
        base_addr   = base;
        start       = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            step();
            start = 1'b0;
            if (cyc == 1) busy_c1 = a_busy;
            if (a_mem_rd_en) begin
                if (rd_cnt < 8) begin
                    rd_cyc[rd_cnt]  = cyc;
                    rd_addr[rd_cnt] = a_mem_addr;
                end
                rd_cnt++;
            end
            if (a_done) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", a_done); end
        n_checks++; if (a_mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %0b want 0", a_mem_rd_en); end
        n_checks++; if (a_err_sum !== 16'd0) begin n_fail++; $display("FAIL reset_err_sum got %0d want 0", a_err_sum); end
        n_checks++; if (a_samples !== 8'd0) begin n_fail++; $display("FAIL reset_samples got %0d want 0", a_samples); end
        n_checks++; if (a_dp_x !== 64'd0) begin n_fail++; $display("FAIL reset_dp_x got %h want 0", a_dp_x); end
    endtask

    task automatic test_single();
        int dc;
        theta_in = {48'h0, 8'd2, 8'd4};
        mem[8'h00] = mk(8'd15, 8'd2, 8'd4);
        run_batch(8'd1, 8'h00, dc);
        n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL single_done_cycle got %0d want 5", dc); end
        n_checks++; if (rd_cnt !== 1 || rd_cyc[0] !== 1) begin n_fail++; $display("FAIL single_rd got count %0d cycle %0d want 1 at 1", rd_cnt, rd_cyc[0]); end
        n_checks++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL single_busy got %0b want 1", busy_c1); end
        n_checks++; if (a_err_sum !== 16'd5) begin n_fail++; $display("FAIL single_err_sum got %0d want 5", a_err_sum); end
        n_checks++; if (a_err_max !== 8'd5) begin n_fail++; $display("FAIL single_err_max got %0d want 5", a_err_max); end
        n_checks++; if (a_samples !== 8'd1) begin n_fail++; $display("FAIL single_samples got %0d want 1", a_samples); end
        n_checks++; if (a_dp_teta !== 64'h0204) begin n_fail++; $display("FAIL single_dp_teta got %h want 0204", a_dp_teta); end
        step();
        n_checks++; if (a_done !== 1'b0 || a_err_sum !== 16'd5) begin n_fail++; $display("FAIL single_hold got done %0b sum %0d want 0 and 5", a_done, a_err_sum); end
    endtask

    task automatic test_batch_wrap();
        int dc;
        theta_in = {48'h0, 8'd2, 8'd4};
        mem[8'hFE] = mk(8'd7,  8'd0, 8'd1);   // h=4,  err 3
        mem[8'hFF] = mk(8'd10, 8'd0, 8'd5);   // h=20, err 10
        mem[8'h00] = mk(8'd11, 8'd1, 8'd2);   // h=10, err 1
        run_batch(8'd3, 8'hFE, dc);
        n_checks++; if (dc !== 13) begin n_fail++; $display("FAIL batch_done_cycle got %0d want 13", dc); end
        n_checks++; if (rd_cnt !== 3) begin n_fail++; $display("FAIL batch_rd_count got %0d want 3", rd_cnt); end
        n_checks++; if (rd_addr[0] !== 8'hFE || rd_cyc[0] !== 1) begin n_fail++; $display("FAIL batch_addr0 got %h@%0d want fe@1", rd_addr[0], rd_cyc[0]); end
        n_checks++; if (rd_addr[1] !== 8'hFF || rd_cyc[1] !== 5) begin n_fail++; $display("FAIL batch_addr1 got %h@%0d want ff@5", rd_addr[1], rd_cyc[1]); end
        n_checks++; if (rd_addr[2] !== 8'h00 || rd_cyc[2] !== 9) begin n_fail++; $display("FAIL batch_addr2 got %h@%0d want 00@9", rd_addr[2], rd_cyc[2]); end
        n_checks++; if (a_err_sum !== 16'd14) begin n_fail++; $display("FAIL batch_err_sum got %0d want 14", a_err_sum); end
        n_checks++; if (a_err_max !== 8'd10) begin n_fail++; $display("FAIL batch_err_max got %0d want 10", a_err_max); end
        n_checks++; if (a_samples !== 8'd3) begin n_fail++; $display("FAIL batch_samples got %0d want 3", a_samples); end
        step();
    endtask

    task automatic test_zero_batch();
        int dc;
        run_batch(8'd0, 8'h40, dc);
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
        n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL zero_rd_count got %0d want 0", rd_cnt); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %0b want 0", a_busy); end
        n_checks++; if (a_err_sum !== 16'd0 || a_err_max !== 8'd0) begin n_fail++; $display("FAIL zero_err got sum %0d max %0d want 0 0", a_err_sum, a_err_max); end
        n_checks++; if (a_samples !== 8'd0) begin n_fail++; $display("FAIL zero_samples got %0d want 0", a_samples); end
        step();
    endtask

    task automatic test_saturation();
        int dc;
        theta_in = {48'h0, 8'd0, 8'd1};
        mem[8'h10] = mk(8'd10, 8'd0, 8'd210);  // h=210, err 200
        mem[8'h11] = mk(8'd200, 8'd0, 8'd0);   // h=0,   err 200
        run_batch(8'd2, 8'h10, dc);
        n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL sat_done_cycle got %0d want 9", dc); end
        n_checks++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL sat_b_done got %0b want 1", b_done); end
        n_checks++; if (b_err_sum !== 8'd255) begin n_fail++; $display("FAIL sat_err_sum got %0d want 255", b_err_sum); end
        n_checks++; if (b_err_max !== 8'd200) begin n_fail++; $display("FAIL sat_err_max got %0d want 200", b_err_max); end
        n_checks++; if (a_err_sum !== 16'd400) begin n_fail++; $display("FAIL sat_wide_sum got %0d want 400", a_err_sum); end
        step();
    endtask

    task automatic test_abort();
        int seen_done = 0;
        int seen_rd   = 0;
        theta_in = {48'h0, 8'd2, 8'd4};
        mem[8'h20] = mk(8'd7, 8'd0, 8'd1);     // err 3
        mem[8'h21] = mk(8'd0, 8'd0, 8'd9);
        num_samples = 8'd4;
        base_addr   = 8'h20;
        start       = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            step();
            start = 1'b0;
            if (cyc == 2) begin
                start       = 1'b1;              // ignored while busy
                num_samples = 8'd1;
            end
            if (a_done) seen_done++;
        end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_c7 got %0b want 1", a_busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy %0b done %0b want 0 0", a_busy, a_done); end
        n_checks++; if (a_samples !== 8'd1) begin n_fail++; $display("FAIL abort_samples got %0d want 1", a_samples); end
        n_checks++; if (a_err_sum !== 16'd3) begin n_fail++; $display("FAIL abort_err_sum got %0d want 3", a_err_sum); end
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            if (a_done) seen_done++;
            if (a_mem_rd_en) seen_rd++;
        end
        n_checks++; if (seen_done !== 0 || seen_rd !== 0) begin n_fail++; $display("FAIL abort_quiet got done %0d rd %0d want 0 0", seen_done, seen_rd); end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL abort_idle_start got busy %0b done %0b want 0 0", a_busy, a_done); end
        num_samples = 8'd0;
    endtask

    task automatic test_reset_mid();
        int dc;
        theta_in = {48'h0, 8'd2, 8'd4};
        mem[8'h30] = mk(8'd7, 8'd0, 8'd1);
        mem[8'h31] = mk(8'd7, 8'd0, 8'd1);
        mem[8'h32] = mk(8'd7, 8'd0, 8'd1);
        num_samples = 8'd3;
        base_addr   = 8'h30;
        start       = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            start = 1'b0;
        end
        rst_n = 1'b0;
        step();
        n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got busy %0b done %0b rd %0b want 0", a_busy, a_done, a_mem_rd_en); end
        n_checks++; if (a_err_sum !== 16'd0 || a_err_max !== 8'd0) begin n_fail++; $display("FAIL rstmid_err got sum %0d max %0d want 0 0", a_err_sum, a_err_max); end
        n_checks++; if (a_samples !== 8'd0 || a_mem_addr !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt got samples %0d addr %h want 0 0", a_samples, a_mem_addr); end
        n_checks++; if (a_dp_x !== 64'd0 || a_dp_teta !== 64'd0) begin n_fail++; $display("FAIL rstmid_dp got x %h teta %h want 0 0", a_dp_x, a_dp_teta); end
        rst_n = 1'b1;
        step();
        mem[8'h00] = mk(8'd15, 8'd2, 8'd4);
        run_batch(8'd1, 8'h00, dc);
        n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL rstmid_rerun_cycle got %0d want 5", dc); end
        n_checks++; if (a_err_sum !== 16'd5 || a_samples !== 8'd1) begin n_fail++; $display("FAIL rstmid_rerun got sum %0d samples %0d want 5 1", a_err_sum, a_samples); end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_samples = 8'd0;
        base_addr   = 8'd0;
        theta_in    = 64'd0;
        for (int i = 0; i < 256; i++) mem[i] = 72'd0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_single();
        test_batch_wrap();
        test_zero_batch();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
